// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic-light subsystem: phase encoding
// and 7-segment patterns ({g,f,e,d,c,b,a}, active-high).
`timescale 1ns/1ps
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        RED    = 2'd2
    } phase_t;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to 7-segment decoder; codes above 9 go dark.
`timescale 1ns/1ps
module seg7_decoder
    import traffic_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_bcd)
            4'd0: o_seg = SEG_0;
            4'd1: o_seg = SEG_1;
            4'd2: o_seg = SEG_2;
            4'd3: o_seg = SEG_3;
            4'd4: o_seg = SEG_4;
            4'd5: o_seg = SEG_5;
            4'd6: o_seg = SEG_6;
            4'd7: o_seg = SEG_7;
            4'd8: o_seg = SEG_8;
            4'd9: o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/top.sv
// Traffic-light controller: prescaler -> 1 s tick, GREEN/YELLOW/RED phase FSM
// with a seconds countdown on two 7-seg digits. SEG_BLANK_ZERO_EN blanks a leading zero.
`timescale 1ns/1ps
module top
    import traffic_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 50,
    parameter int unsigned GREEN_TIME  = 25,
    parameter int unsigned YELLOW_TIME = 3,
    parameter int unsigned RED_TIME    = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic       green_light,
    output logic       yellow_light,
    output logic       red_light,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_units
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    phase_t        r_state, w_state_nxt;
    logic [6:0]    r_cnt, w_cnt_nxt;
    logic [PW-1:0] r_pre, w_pre_nxt;
    logic          w_tick;
    logic [3:0]    w_tens;
    logic [6:0]    w_units;
    logic [6:0]    w_seg_tens_raw;

    function automatic logic [6:0] phase_len(input phase_t p);
        case (p)
            YELLOW:  return 7'(YELLOW_TIME);
            RED:     return 7'(RED_TIME);
            default: return 7'(GREEN_TIME);
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= GREEN;
            r_cnt   <= 7'(GREEN_TIME);
            r_pre   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pre   <= w_pre_nxt;
        end
    end

    always_comb begin
        w_tick      = en && (r_pre == PRE_LAST);
        w_pre_nxt   = r_pre;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (en)
            w_pre_nxt = (r_pre == PRE_LAST) ? '0 : r_pre + PW'(1);
        if (w_tick) begin
            if (r_cnt == 7'd1) begin
                case (r_state)
                    GREEN:   w_state_nxt = YELLOW;
                    YELLOW:  w_state_nxt = RED;
                    default: w_state_nxt = GREEN;
                endcase
                w_cnt_nxt = phase_len(w_state_nxt);
            end else begin
                w_cnt_nxt = r_cnt - 7'd1;
            end
        end
    end

    always_comb begin
        green_light  = (r_state == GREEN);
        yellow_light = (r_state == YELLOW);
        red_light    = (r_state == RED);
    end

    // cnt <= 99, so nine conditional subtractions of ten yield the tens digit
    always_comb begin
        w_tens  = '0;
        w_units = r_cnt;
        for (int unsigned i = 0; i < 9; i++) begin
            if (w_units >= 7'd10) begin
                w_units = w_units - 7'd10;
                w_tens  = w_tens + 4'd1;
            end
        end
    end

    seg7_decoder u_dec_tens (
        .i_bcd (w_tens),
        .o_seg (w_seg_tens_raw)
    );

    seg7_decoder u_dec_units (
        .i_bcd (w_units[3:0]),
        .o_seg (seg_units)
    );

`ifdef SEG_BLANK_ZERO_EN
    assign seg_tens = (w_tens == 4'd0) ? SEG_BLANK : w_seg_tens_raw;
`else
    assign seg_tens = w_seg_tens_raw;
`endif

endmodule

// File: tb/tb_top.sv
// Self-checking bench for top: directed sequence plus random enable bursts,
// checked against an elapsed-time model of the light schedule.
`timescale 1ns/1ps
module tb_top;

    localparam int D = 50;
    localparam int G = 25;
    localparam int Y = 3;
    localparam int R = 30;

    logic       clk = 1'b0;
    logic       rst, en, en_f;
    logic       g, y, r, gf, yf, rf;
    logic [6:0] st, su, stf, suf;

    int e, e_f, nchk, nerr;
    logic [6:0] segtab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    always #5 clk = ~clk;

    top u_dut (
        .clk(clk), .rst(rst), .en(en),
        .green_light(g), .yellow_light(y), .red_light(r),
        .seg_tens(st), .seg_units(su)
    );

    top #(.TICK_DIV(1), .GREEN_TIME(1), .YELLOW_TIME(1), .RED_TIME(1)) u_fast (
        .clk(clk), .rst(rst), .en(en_f),
        .green_light(gf), .yellow_light(yf), .red_light(rf),
        .seg_tens(stf), .seg_units(suf)
    );

    // Phase and remaining seconds after ev enabled cycles since reset
    task automatic model(input int ev, input int dv, input int gt, input int yt, input int rt,
                         output int ph, output int c);
        int m;
        m = ev % ((gt + yt + rt) * dv);
        if (m < gt * dv) begin
            ph = 0; c = gt - m / dv;
        end else if (m < (gt + yt) * dv) begin
            ph = 1; c = yt - (m - gt * dv) / dv;
        end else begin
            ph = 2; c = rt - (m - (gt + yt) * dv) / dv;
        end
    endtask

    function automatic logic [2:0] lamps(input int ph);
        return (ph == 0) ? 3'b100 : (ph == 1) ? 3'b010 : 3'b001;
    endfunction

    function automatic logic [6:0] exp_tens(input int t);
`ifdef SEG_BLANK_ZERO_EN
        if (t == 0) return 7'h00;
`endif
        return segtab[t];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_main(input string tag);
        int ph, c;
        model(e, D, G, Y, R, ph, c);
        chk({tag, " lamps"}, {29'd0, g, y, r}, {29'd0, lamps(ph)});
        chk({tag, " tens"}, {25'd0, st}, {25'd0, exp_tens(c / 10)});
        chk({tag, " units"}, {25'd0, su}, {25'd0, segtab[c % 10]});
        chk({tag, " pre"}, 32'(u_dut.r_pre), 32'(e % D));
    endtask

    task automatic check_fast(input string tag);
        int ph, c;
        model(e_f, 1, 1, 1, 1, ph, c);
        chk({tag, " lamps"}, {29'd0, gf, yf, rf}, {29'd0, lamps(ph)});
        chk({tag, " tens"}, {25'd0, stf}, {25'd0, exp_tens(c / 10)});
        chk({tag, " units"}, {25'd0, suf}, {25'd0, segtab[c % 10]});
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst && en) e++;
        if (!rst && en_f) e_f++;
        @(negedge clk);
    endtask

    initial begin
        int ph, c, n;
        bit found;
        nchk = 0; nerr = 0; e = 0; e_f = 0;
        rst = 1'b1; en = 1'b0; en_f = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        check_main("reset");
        chk("reset tens 2", {25'd0, st}, 32'h5B);
        chk("reset units 5", {25'd0, su}, 32'h6D);
        repeat (5) begin step(); check_main("hold_en0"); end

        en = 1'b1;
        repeat (50) step();
        check_main("first_tick");
        chk("first_tick units 4", {25'd0, su}, 32'h66);
        repeat (1200) step();
        check_main("to_yellow");
        chk("yellow lamp", {31'd0, y}, 32'd1);
        repeat (150) step();
        check_main("to_red");
        chk("red units 0", {25'd0, su}, 32'h3F);
        repeat (1500) step();
        check_main("to_green");

        repeat (3500) begin
            step();
            chk("onehot", 32'($countones({g, y, r})), 32'd1);
            check_main("run");
        end

        // now mid-green with prescaler partway through a second
        repeat (23) step();
        en = 1'b0;
        repeat (37) begin step(); check_main("freeze"); end
        en = 1'b1;
        repeat (120) begin step(); check_main("resume"); end

        repeat (150) begin
            en = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 40);
            repeat (n) begin step(); check_main("rand"); end
        end

        en = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            step();
            model(e, D, G, Y, R, ph, c);
            if (ph == 2 && c == 15 && (e % D) == 17) found = 1'b1;
        end
        chk("reach_mid_red", {31'd0, found}, 32'd1);
        #2 rst = 1'b1;
        e = 0; e_f = 0;
        #1 check_main("async_rst");
        #1 rst = 1'b0;
        repeat (10) begin step(); check_main("after_rst"); end

        check_fast("fast_idle");
        en_f = 1'b1;
        repeat (6) begin step(); check_fast("fast_rot"); end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/top.md
Name: top

Overview:
- Single-intersection traffic-light controller: fixed GREEN→YELLOW→RED→GREEN sequence with per-phase durations in "seconds".
- Shows the remaining seconds of the current phase on two 7-segment digits (tens, units).
- Top of the traffic subsystem. A prescaler divides the system clock into a 1-second tick, and a phase FSM counts ticks.

Parameters:
TICK_DIV, 50, clock cycles per one-second tick (≥1)
GREEN_TIME, 25, green phase length in ticks (1..99)
YELLOW_TIME, 3, yellow phase length in ticks (1..99)
RED_TIME, 30, red phase length in ticks (1..99)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
en  input  1  run enable; low freezes all timing
green_light  output  1  green lamp, active-high
yellow_light  output  1  yellow lamp, active-high
red_light  output  1  red lamp, active-high
seg_tens  output  7  tens digit segments {g,f,e,d,c,b,a}, active-high
seg_units  output  7  units digit segments {g,f,e,d,c,b,a}, active-high

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Registers:
  - prescaler `pre` is [$clog2(TICK_DIV)-1:0] wide (1 bit minimum).
  - phase state is GREEN, YELLOW or RED.
  - seconds counter `cnt` is 7 bits.
- Reset (asserted, at any time, including mid-phase):
  - state=GREEN, cnt=GREEN_TIME, pre=0.
  - Outputs are then green_light=1, other lamps 0, display shows GREEN_TIME.
- Prescaler:
  - When en=1: pre increments each cycle and wraps to 0 after TICK_DIV-1.
  - tick = en && (pre==TICK_DIV-1).
  - When en=0: pre, cnt and state all hold.
- On tick:
  - If cnt==1: advance state (GREEN→YELLOW, YELLOW→RED, RED→GREEN) and load cnt with the new phase's TIME.
  - Else: cnt decrements by 1.
  - cnt never shows 0.
- Phase length is exactly TIME×TICK_DIV enabled cycles. Each displayed value persists TICK_DIV enabled cycles.
- Lamps: combinational one-hot decode of the state register, so exactly one lamp is high at all times. A state change is visible after the clock edge on which the tick occurs; there is no extra latency.
- Display: tens = cnt/10 and units = cnt%10, computed combinationally (subtract/compare; no divider IP required).
- Segment encoding, digits 0..9: 3F,06,5B,4F,66,6D,7D,07,7F,6F. Any code above 9 drives 7'h00.
- Deasserting en mid-phase and re-asserting resumes at the exact pre/cnt values.
- Full cycle length: (GREEN_TIME+YELLOW_TIME+RED_TIME)×TICK_DIV = 2900 cycles at defaults.

Optional Feature:
- Macro SEG_BLANK_ZERO_EN.
  - Defined: seg_tens drives 7'h00 (blank) whenever tens digit is 0, e.g. "03" displays as " 3".
  - Undefined: leading zero shown (seg_tens=7'h3F).
- Lamps, timing and seg_units are unaffected either way.

Decomposition:
- Package traffic_pkg:
  - phase enum (GREEN=2'd0, YELLOW=2'd1, RED=2'd2).
  - the ten 7-bit segment constants and SEG_BLANK=7'h00.
- Sub-module seg7_decoder: 4-bit BCD in, 7-bit segments out, combinational. Instantiated twice in top.
- Prescaler, FSM, counter and BCD split stay in top.

Test Plan (default parameters):
- Reset: hold rst=1 with en=0, then rst=0 → green=1, yellow=0, red=0, seg_tens=5B, seg_units=6D; values hold while en=0.
- Countdown: en=1 for 50 cycles → display 24 (5B,66). After 1250 enabled cycles → yellow=1, display 03 (3F,4F), or tens 00 with SEG_BLANK_ZERO_EN.
- Sequence: 150 more cycles → red=1, display 30 (4F,3F). 1500 more cycles → green=1, display 25. Run 3500 cycles checking one-hot lamps every cycle.
- Enable freeze: drop en for 37 cycles mid-green → lamps, segments and internal pre unchanged. Re-enable → next decrement after the remaining prescaler cycles; total phase stays 1250 enabled cycles.
- Async reset mid-red: pulse rst between clock edges → green=1, display 25 immediately, without waiting for a clock edge.
- TICK_DIV=1, all TIMEs=1 → lamps rotate every cycle G,Y,R,G with display 01 constant.
